// File: rtl/fifo_wr_status_sync_if.sv
// Status bundle between the write-domain status block and its user.
// The master drives the request, both pointers and the overflow clear.
// The slave (fifo_wr_status_sync) returns the gated enable and the fill flags.
interface fifo_wr_status_sync_if #(
  parameter int unsigned depth = 8
) ();

  logic             wr_request;
  logic [depth-1:0] wr_gray;
  logic [depth-1:0] rd_gray;
  logic             overflow_clear;
  logic             wr_enable;
  logic             full;
  logic             almost_full;
  logic [depth-1:0] level;
  logic             overflow;
  logic             gray_error;

  modport master (
    output wr_request,
    output wr_gray,
    output rd_gray,
    output overflow_clear,
    input  wr_enable,
    input  full,
    input  almost_full,
    input  level,
    input  overflow,
    input  gray_error
  );

  modport slave (
    input  wr_request,
    input  wr_gray,
    input  rd_gray,
    input  overflow_clear,
    output wr_enable,
    output full,
    output almost_full,
    output level,
    output overflow,
    output gray_error
  );

endinterface

// File: rtl/fifo_wr_status_sync.sv
// Write-domain status for the dual-clock FIFO.
// The block brings the read-pointer Gray code into wr_clock through a synchroniser.
// It decodes both pointers to binary and derives level, full and almost_full.
// It gates writes with full and keeps a sticky overflow flag.
// Optional macro FIFO_GRAY_CHECK_EN adds a sticky multi-bit-change detector on the
// synchronised read pointer (gray_error); without it gray_error is tied to 0.
module fifo_wr_status_sync #(
  parameter int unsigned depth              = 8,
  parameter int unsigned sync_stages        = 2,
  parameter int unsigned almost_full_margin = 2
) (
  input logic                   wr_clock,
  input logic                   reset_n,
  fifo_wr_status_sync_if.slave  status_if
);

  localparam int unsigned      Capacity  = 1 << (depth - 1);
  localparam logic [depth-1:0] FullLevel = depth'(Capacity);
  localparam logic [depth-1:0] AfLevel   = depth'(Capacity - almost_full_margin);

  function automatic logic [depth-1:0] gray2bin(input logic [depth-1:0] g);
    logic [depth-1:0] bin;
    bin[depth-1] = g[depth-1];
    for (int i = int'(depth) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ g[i];
    end
    return bin;
  endfunction

  logic [depth-1:0] sync_q [sync_stages];
  logic [depth-1:0] sync_d [sync_stages];
  logic [depth-1:0] rd_gray_s;
  logic [depth-1:0] rd_bin_q, rd_bin_d;
  logic [depth-1:0] wr_bin;
  logic [depth-1:0] level;
  logic             full;
  logic             overflow_q, overflow_d;

  // Plain shift chain: nothing between stages so each flop only ever sees a flop output.
  always_comb begin
    sync_d[0] = status_if.rd_gray;
    for (int unsigned i = 1; i < sync_stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rd_gray_s = sync_q[sync_stages-1];

  // Synchroniser flops.
  always_ff @(posedge wr_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < sync_stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  // Read pointer is decoded into a register; the write pointer is already registered upstream.
  always_comb begin
    rd_bin_d = gray2bin(rd_gray_s);
    wr_bin   = gray2bin(status_if.wr_gray);
  end

  // Fill arithmetic: modulo subtraction absorbs pointer wrap with no special case.
  always_comb begin
    level = wr_bin - rd_bin_q;
    full  = (level == FullLevel);
  end

  // Overflow flag: a rejected write wins over a clear in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (status_if.wr_request && full) begin
      overflow_d = 1'b1;
    end else if (status_if.overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  // Decoded read pointer and sticky overflow.
  always_ff @(posedge wr_clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_bin_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FIFO_GRAY_CHECK_EN
  logic [depth-1:0] prev_gray_q, prev_gray_d;
  logic [depth-1:0] gray_diff;
  logic             seen_one, multi_bit;
  logic             gray_error_q, gray_error_d;

  // A legal Gray sequence changes at most one bit per sampled step.
  always_comb begin
    prev_gray_d  = rd_gray_s;
    gray_diff    = rd_gray_s ^ prev_gray_q;
    seen_one     = 1'b0;
    multi_bit    = 1'b0;
    for (int unsigned i = 0; i < depth; i++) begin
      if (gray_diff[i]) begin
        if (seen_one) begin
          multi_bit = 1'b1;
        end
        seen_one = 1'b1;
      end
    end
    gray_error_d = gray_error_q | multi_bit;
  end

  // Previous-sample register and sticky error; reset seeds the comparison with 0.
  always_ff @(posedge wr_clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_gray_q  <= '0;
      gray_error_q <= 1'b0;
    end else begin
      prev_gray_q  <= prev_gray_d;
      gray_error_q <= gray_error_d;
    end
  end

  assign status_if.gray_error = gray_error_q;
`else
  assign status_if.gray_error = 1'b0;
`endif

  assign status_if.level       = level;
  assign status_if.full        = full;
  assign status_if.almost_full = (level >= AfLevel);
  assign status_if.wr_enable   = status_if.wr_request & ~full;
  assign status_if.overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_status_sync.sv
// Scoreboard bench for fifo_wr_status_sync at depth 8, sync_stages 2, margin 2.
// The driver applies one vector per cycle and queues its expected outputs.
// The monitor pops one entry per falling edge and compares it with the DUT outputs.
module tb_fifo_wr_status_sync;

  localparam int unsigned Depth = 8;
`ifdef FIFO_GRAY_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic wr_clock = 1'b0;
  logic reset_n  = 1'b0;

  fifo_wr_status_sync_if #(.depth(Depth)) bus ();

  fifo_wr_status_sync #(
    .depth             (Depth),
    .sync_stages       (2),
    .almost_full_margin(2)
  ) dut (
    .wr_clock (wr_clock),
    .reset_n  (reset_n),
    .status_if(bus)
  );

  always #5 wr_clock = ~wr_clock;

  typedef struct packed {
    logic       en;
    logic       full;
    logic       af;
    logic       ov;
    logic       ge;
    logic [7:0] lvl;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [7:0] g(input int unsigned b);
    logic [7:0] v;
    v = 8'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic push_exp(input string nm, input logic en, input logic full, input logic af,
                          input logic [7:0] lvl, input logic ov, input logic ge);
    exp_t e;
    e.en   = en;
    e.full = full;
    e.af   = af;
    e.ov   = ov;
    e.ge   = ge;
    e.lvl  = lvl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One cycle: apply inputs just after the rising edge, check at the falling edge.
  task automatic step(input string nm, input logic req, input logic [7:0] wg,
                      input logic [7:0] rg, input logic clr, input logic en,
                      input logic full, input logic af, input logic [7:0] lvl,
                      input logic ov, input logic ge);
    bus.wr_request     = req;
    bus.wr_gray        = wg;
    bus.rd_gray        = rg;
    bus.overflow_clear = clr;
    push_exp(nm, en, full, af, lvl, ov, ge);
    @(posedge wr_clock);
    #1;
  endtask

  // Reset is checked while reset_n is still low, so the clear must be asynchronous.
  task automatic do_reset(input string nm, input logic [7:0] wg, input logic [7:0] lvl);
    reset_n            = 1'b0;
    bus.wr_request     = 1'b0;
    bus.wr_gray        = wg;
    bus.rd_gray        = 8'h00;
    bus.overflow_clear = 1'b0;
    push_exp(nm, 1'b0, 1'b0, 1'b0, lvl, 1'b0, 1'b0);
    @(negedge wr_clock);
    @(posedge wr_clock);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge wr_clock) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  act;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act.en   = bus.wr_enable;
      act.full = bus.full;
      act.af   = bus.almost_full;
      act.ov   = bus.overflow;
      act.ge   = bus.gray_error;
      act.lvl  = bus.level;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got en=%b full=%b af=%b ov=%b ge=%b level=%0d, expected en=%b full=%b af=%b ov=%b ge=%b level=%0d",
                 nm, act.en, act.full, act.af, act.ov, act.ge, act.lvl,
                 e.en, e.full, e.af, e.ov, e.ge, e.lvl);
      end
    end
  end

  initial begin
    bus.wr_request     = 1'b0;
    bus.wr_gray        = 8'h00;
    bus.rd_gray        = 8'h00;
    bus.overflow_clear = 1'b0;

    do_reset("reset", 8'h00, 8'd0);
    step("reset_req", 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Fill to capacity with the read pointer parked at 0.
    for (int i = 0; i <= 128; i++) begin
      step("fill", 1'b1, g(i), 8'h00, 1'b0, (i < 128), (i == 128), (i >= 126), 8'(i),
           1'b0, 1'b0);
    end
    step("ovf_set", 1'b1, g(128), 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'd128, 1'b1, 1'b0);

    // One entry freed: visible after three write-clock edges.
    for (int j = 0; j <= 3; j++) begin
      step("free", 1'b1, g(128), g(1), 1'b0, (j == 3), (j < 3), 1'b1,
           (j == 3) ? 8'd127 : 8'd128, 1'b1, 1'b0);
    end
    step("free_hold", 1'b1, g(128), g(1), 1'b0, 1'b1, 1'b0, 1'b1, 8'd127, 1'b1, 1'b0);

    // Clear while not full.
    step("clr_nf", 1'b0, g(128), g(1), 1'b1, 1'b0, 1'b0, 1'b1, 8'd127, 1'b1, 1'b0);
    step("clr_nf_done", 1'b0, g(128), g(1), 1'b0, 1'b0, 1'b0, 1'b1, 8'd127, 1'b0, 1'b0);

    // Set beats clear when both occur on the same edge.
    step("ovf_full", 1'b1, g(129), g(1), 1'b0, 1'b0, 1'b1, 1'b1, 8'd128, 1'b0, 1'b0);
    step("clr_and_set", 1'b1, g(129), g(1), 1'b1, 1'b0, 1'b1, 1'b1, 8'd128, 1'b1, 1'b0);
    step("set_wins", 1'b0, g(129), g(1), 1'b0, 1'b0, 1'b1, 1'b1, 8'd128, 1'b1, 1'b0);
    step("clr_full", 1'b0, g(129), g(1), 1'b1, 1'b0, 1'b1, 1'b1, 8'd128, 1'b1, 1'b0);
    step("clr_full_done", 1'b0, g(129), g(1), 1'b0, 1'b0, 1'b1, 1'b1, 8'd128, 1'b0, 1'b0);

    // Move both pointers to 250. The old rd_bin of 1 gives level 249 until the sync lands.
    // g(1)->g(250) changes three bits, which the integrity check flags.
    for (int j = 0; j <= 3; j++) begin
      step("wrap_sync", 1'b0, g(250), g(250), 1'b0, 1'b0, 1'b0, (j < 3),
           (j < 3) ? 8'd249 : 8'd0, 1'b0, ChkEn && (j == 3));
    end
    for (int k = 0; k <= 10; k++) begin
      step("wrap", 1'b1, g(250 + k), g(250), 1'b0, 1'b1, 1'b0, 1'b0, 8'(k), 1'b0, ChkEn);
    end

    // Mid-run reset: rd_bin clears at once, so level reflects wr_gray alone.
    do_reset("reset_mid", g(5), 8'd5);

    // rd_gray 00 -> 03 changes two bits. rd_bin becomes 2 and gray_error latches on edge 3.
    for (int j = 0; j <= 5; j++) begin
      step("gray_jump", 1'b0, g(2), 8'h03, 1'b0, 1'b0, 1'b0, 1'b0,
           (j < 3) ? 8'd2 : 8'd0, 1'b0, ChkEn && (j >= 3));
    end
    do_reset("reset_end", 8'h00, 8'd0);
    step("post_reset", 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) begin
      @(negedge wr_clock);
    end
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
